// File: rtl/valu_seq_pkg.sv
// Shared constants, op codes and FSM state type for the vector ALU sequencer.
// Geometry: N-bit lanes, M lanes per chunk, CHUNKS chunks per register, RW-bit register index.
package valu_seq_pkg;

    localparam int N      = 24;
    localparam int M      = 6;
    localparam int CHUNKS = 4;
    localparam int RW     = 3;
    localparam int CW     = $clog2(CHUNKS);
    localparam int AW     = RW + CW;
    localparam int DW     = M * N;

    localparam logic [3:0] OP_MOV  = 4'd0;
    localparam logic [3:0] OP_CMP  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_MOD  = 4'd9;
    localparam logic [3:0] OP_LAST = OP_MOD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_e;

    // cmp only produces flags; every other op writes its result back.
    function automatic logic has_writeback(input logic [3:0] op);
        return op != OP_CMP;
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/valu_seq_if.sv
// Bundle of decode handshake, register-file port and ALU port seen by valu_seq.
// slave = the sequencer side; master = decode/ALU/register-file environment side.
interface valu_seq_if;
    import valu_seq_pkg::*;

    logic              start_valid;
    logic              start_ready;
    logic [3:0]        op;
    logic [RW-1:0]     vd;
    logic [RW-1:0]     va;
    logic [RW-1:0]     vb;
    logic [CW-1:0]     len_m1;

    logic [AW-1:0]     rf_raddr_a;
    logic [AW-1:0]     rf_raddr_b;
    logic [DW-1:0]     rf_rdata_a;
    logic [DW-1:0]     rf_rdata_b;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;

    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [3:0]        alu_select;
    logic [DW-1:0]     alu_result;
    logic [1:0]        alu_flags;

    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        flags_out;

    modport slave (
        input  start_valid, op, vd, va, vb, len_m1,
        input  rf_rdata_a, rf_rdata_b, alu_result, alu_flags,
        output start_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
        output alu_a, alu_b, alu_select, busy, done, err, flags_out
    );

    modport master (
        output start_valid, op, vd, va, vb, len_m1,
        output rf_rdata_a, rf_rdata_b, alu_result, alu_flags,
        input  start_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
        input  alu_a, alu_b, alu_select, busy, done, err, flags_out
    );

endinterface

// File: rtl/valu_seq.sv
// Vector ALU sequencer: READ -> EXEC -> WRITE per chunk, then a one-cycle DONE pulse.
// Optional VALU_SEQ_ABORT_EN adds an abort input that ends the instruction early with err.
module valu_seq
    import valu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
`ifdef VALU_SEQ_ABORT_EN
    input  logic       abort,
`endif
    valu_seq_if.slave  bus
);

    state_e        state_q, state_d;
    logic          alive_q;
    logic [3:0]    op_q;
    logic [RW-1:0] vd_q, va_q, vb_q;
    logic [CW-1:0] len_q, chunk_q;
    logic [DW-1:0] result_q;
    logic [1:0]    flags_q;
    logic          err_q;
    logic [DW-1:0] alu_a_q, alu_b_q;
    logic [3:0]    sel_q;

    logic          accept;
    logic          abort_hit;
    logic          in_exec;
    logic          last_chunk;

`ifdef VALU_SEQ_ABORT_EN
    assign abort_hit = abort && (state_q inside {ST_READ, ST_EXEC, ST_WRITE});
`else
    assign abort_hit = 1'b0;
`endif

    assign in_exec    = (state_q == ST_EXEC);
    assign last_chunk = (chunk_q == len_q);

    // alive_q keeps start_ready low while reset is asserted without a comb path from rst_n.
    assign bus.start_ready = alive_q && (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.err         = err_q;
    assign bus.flags_out   = flags_q;

    assign bus.rf_raddr_a  = {va_q, chunk_q};
    assign bus.rf_raddr_b  = {vb_q, chunk_q};
    assign bus.rf_waddr    = {vd_q, chunk_q};
    assign bus.rf_wdata    = result_q;

    assign bus.alu_a       = in_exec ? bus.rf_rdata_a : alu_a_q;
    assign bus.alu_b       = in_exec ? bus.rf_rdata_b : alu_b_q;
    assign bus.alu_select  = in_exec ? op_q : sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: state and datapath registers use non-blocking assignment so every
            // flop samples pre-edge values regardless of process ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a signal unassigned and no latch can be inferred.
        state_d    = state_q;
        accept     = 1'b0;
        bus.rf_we  = 1'b0;
        bus.done   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_valid && bus.start_ready) begin
                    accept  = 1'b1;
                    state_d = is_legal(bus.op) ? ST_READ : ST_DONE;
                end
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: begin
                bus.rf_we = has_writeback(op_q);
                state_d   = last_chunk ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_hit) begin
            bus.rf_we = 1'b0;
            state_d   = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q  <= 1'b0;
            op_q     <= '0;
            vd_q     <= '0;
            va_q     <= '0;
            vb_q     <= '0;
            len_q    <= '0;
            chunk_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (accept) begin
                op_q    <= bus.op;
                vd_q    <= bus.vd;
                va_q    <= bus.va;
                vb_q    <= bus.vb;
                len_q   <= bus.len_m1;
                chunk_q <= '0;
                flags_q <= '0;
                err_q   <= !is_legal(bus.op);
            end else if (abort_hit) begin
                err_q <= 1'b1;
            end else if (state_q == ST_EXEC) begin
                result_q <= bus.alu_result;
                flags_q  <= flags_q | bus.alu_flags;
            end else if (state_q == ST_WRITE && !last_chunk) begin
                chunk_q <= chunk_q + 1'b1;
            end
        end
    end

    // ALU operand hold registers track whatever was presented during EXEC, aborted or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q <= '0;
            alu_b_q <= '0;
            sel_q   <= '0;
        end else if (in_exec) begin
            alu_a_q <= bus.rf_rdata_a;
            alu_b_q <= bus.rf_rdata_b;
            sel_q   <= op_q;
        end
    end

endmodule
